modulus_lut_gen: RTL and testbench
==================================

# modulus_lut_gen

Runtime-loadable generator and store for the modular-reduction digit table used by the squarer's reduction tree. On a load handshake it takes a modulus M, computes B = 2^LOW_POS mod M by repeated modular doubling, then fills entry[i] = i·B mod M for i = 0..2^DIGIT_BITS-1 by modular accumulation. It then serves single-cycle registered lookups. It replaces the elaboration-time ROM so one bitstream can serve any modulus.

## Interface
- MODULUS_WIDTH, 1024, width of M and of every table entry
- DIGIT_BITS, 6, lookup digit width; table depth is 2^DIGIT_BITS
- LOW_POS, 2042, bit position of the digit's LSB; must be ≥ 1 (elaboration assertion)
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- load_valid  in  1  modulus offered
- load_ready  out  1  block can accept a modulus
- modulus_in  in  MODULUS_WIDTH  modulus M, sampled on handshake
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse when the table becomes valid
- load_err  out  1  one-cycle pulse when a modulus is rejected
- table_valid  out  1  table holds a complete table for the last accepted M
- rd_digit  in  DIGIT_BITS  lookup index
- rd_data  out  MODULUS_WIDTH  entry[rd_digit], registered

## Operation
- States: IDLE, DOUBLE, FILL.
- IDLE: load_ready=1. A handshake occurs when load_valid && load_ready at the edge.
  - If modulus_in < 2: pulse load_err, stay in IDLE. table_valid and the table are unchanged.
  - Otherwise: latch M, set r=1, write entry[0]=0, clear table_valid, go to DOUBLE.
- DOUBLE: r ← (2r ≥ M) ? 2r−M : 2r, computed at MODULUS_WIDTH+1 bits. Runs exactly LOW_POS cycles, then B=r and the block goes to FILL with acc=0.
- FILL: acc ← (acc+B ≥ M) ? acc+B−M : acc+B, at MODULUS_WIDTH+1 bits. Writes entry[k]=acc for k = 1..2^DIGIT_BITS−1, one per cycle. Wrap past M is normal; for example, an entry can be 0.
- After the last write: table_valid=1, one-cycle done pulse, return to IDLE.
- load_ready=0 in DOUBLE and FILL. load_valid is ignored there, and a held request is taken in IDLE.
- busy=1 exactly while in DOUBLE or FILL.
- Reads are always accepted.
  - rd_data = entry[rd_digit] when table_valid was 1 at sampling.
  - rd_data = 0 otherwise, so there is no stale or partial data.
- Reset: to IDLE. load_ready=1, busy=0, done=0, load_err=0, table_valid=0, rd_data=0. Table contents are don't-care. Reset mid-DOUBLE or mid-FILL abandons the fill, and a new load is required.

## Timing
- Handshake at edge T, then busy=1 from T+1.
- DOUBLE occupies edges T+1..T+LOW_POS.
- FILL writes occupy edges T+LOW_POS+1..T+LOW_POS+2^DIGIT_BITS−1.
- table_valid=1, done=1, busy=0 and load_ready=1 all appear after edge T+LOW_POS+2^DIGIT_BITS.
- Generation latency is LOW_POS+2^DIGIT_BITS cycles; the defaults give 2106.
- Read latency is 1 cycle: rd_digit sampled at edge N gives rd_data valid after edge N.
- A read and the final write in the same cycle: the read sees table_valid=0 and returns 0.

## Configuration
- MODLUT_OUT_REG_EN defined: a second register stage is added on rd_data for timing closure at 1024 bits.
  - Read latency becomes 2.
  - The table_valid gating is sampled at the first stage.
  - Both stages reset to 0.
- Undefined: read latency is 1, as above.

## Structure
- Package modlut_pkg holds:
  - the state enum (IDLE, DOUBLE, FILL)
  - the localparams TABLE_DEPTH = 2^DIGIT_BITS and CNT_WIDTH = clog2(max(LOW_POS, TABLE_DEPTH)+1)
- Sub-module modlut_addmod computes (a+b) mod M for a,b < M with a single conditional subtract. Shared use:
  - DOUBLE instantiates it with a=b=r.
  - FILL instantiates it with a=acc, b=B.
- The table is distributed RAM (rom_style/ram_style "distributed"), 2^DIGIT_BITS × MODULUS_WIDTH, with one write port and one registered read port.

## Test plan
- MODULUS_WIDTH=8, DIGIT_BITS=2, LOW_POS=4, load M=13 → done after 8 cycles; entries 0,3,6,9; busy high 8 cycles.
- MODULUS_WIDTH=8, DIGIT_BITS=3, LOW_POS=3, M=7 → entries 0,1,2,3,4,5,6,0 (wrap to 0 at i=7).
- Load M=1, then M=0 → load_err pulses each time, no busy, table_valid unchanged; a prior valid table still reads correctly.
- Defaults, with M from `MODULUS_DEF → all 64 entries match the model (i<<2042) % M. Read latency 1, or 2 with MODLUT_OUT_REG_EN.
- Load during FILL, plus reset asserted mid-DOUBLE → load_ready=0 and load ignored. After reset: table_valid=0, rd_data=0, load_ready=1. A reload completes correctly.
- Back-to-back loads M=13 then M=11 (held load_valid) → second accepted in the cycle after done. table_valid drops on the second accept and table rises to 0,5,10,4 (LOW_POS=4, 16 mod 11=5).

Source files
------------

// File: rtl/modlut_pkg.sv
// Shared types and sizing helpers for the modulus digit-table generator.
package modlut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOUBLE,
    FILL
  } state_t;

  localparam int MODULUS_WIDTH_DEF = 1024;
  localparam int DIGIT_BITS_DEF    = 6;
  localparam int LOW_POS_DEF       = 2042;

  function automatic int table_depth(input int digit_bits);
    return 1 << digit_bits;
  endfunction

  // Counter must hold both the doubling count and the fill count.
  function automatic int cnt_width(input int low_pos, input int digit_bits);
    int depth;
    int span;
    depth = table_depth(digit_bits);
    span  = (low_pos > depth) ? low_pos : depth;
    return $clog2(span + 1);
  endfunction

  localparam int TABLE_DEPTH = table_depth(DIGIT_BITS_DEF);
  localparam int CNT_WIDTH   = cnt_width(LOW_POS_DEF, DIGIT_BITS_DEF);

endpackage

// File: rtl/modlut_addmod.sv
// (a + b) mod m for a, b < m, using one conditional subtract.
module modlut_addmod
  import modlut_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] y
);

  logic [W:0]   sum;
  logic [W-1:0] diff_lo;

  assign sum = {1'b0, a} + {1'b0, b};
  // The reduced result is below m, so the low W bits of the difference suffice.
  assign diff_lo = sum[W-1:0] - m;
  assign y = (sum >= {1'b0, m}) ? diff_lo : sum[W-1:0];

endmodule

// File: rtl/modulus_lut_gen.sv
// Loads a modulus M, derives B = 2^LOW_POS mod M, fills entry[i] = i*B mod M, then serves lookups.
// Define MODLUT_OUT_REG_EN to add a second rd_data register stage (read latency 2).
//
// state  | meaning
// IDLE   | ready for a modulus; table served if valid
// DOUBLE | modular doubling of r, LOW_POS cycles
// FILL   | modular accumulation of B into entries 1..depth-1, then finish
module modulus_lut_gen
  import modlut_pkg::*;
#(
  parameter int MODULUS_WIDTH = 1024,
  parameter int DIGIT_BITS    = 6,
  parameter int LOW_POS       = 2042
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [MODULUS_WIDTH-1:0] modulus_in,
  output logic                     busy,
  output logic                     done,
  output logic                     load_err,
  output logic                     table_valid,
  input  logic [DIGIT_BITS-1:0]    rd_digit,
  output logic [MODULUS_WIDTH-1:0] rd_data
);

  localparam int DEPTH = table_depth(DIGIT_BITS);
  localparam int CW    = cnt_width(LOW_POS, DIGIT_BITS);

  if (LOW_POS < 1) begin : g_bad_low_pos
    $error("modulus_lut_gen: LOW_POS must be at least 1");
  end

  state_t state, state_nxt;

  logic [MODULUS_WIDTH-1:0] mod_q, work_q, step_q, sum;
  logic [MODULUS_WIDTH-1:0] add_b;
  logic [CW-1:0]            cnt_q;
  logic [DIGIT_BITS-1:0]    wr_idx_q;
  logic                     accept, mod_ok, cnt_tc;
  logic                     tv_q, done_q, err_q;

  logic                     mem_we;
  logic [DIGIT_BITS-1:0]    mem_waddr;
  logic [MODULUS_WIDTH-1:0] mem_wdata;
  logic [MODULUS_WIDTH-1:0] rd_q;

  (* ram_style = "distributed" *) logic [MODULUS_WIDTH-1:0] mem [DEPTH];

  assign accept = load_valid && load_ready;
  assign mod_ok = modulus_in >= MODULUS_WIDTH'(2);
  assign cnt_tc = (cnt_q == CW'(1));

  // One adder serves both phases: r+r while doubling, acc+B while filling.
  assign add_b = (state == FILL) ? step_q : work_q;

  modlut_addmod #(.W(MODULUS_WIDTH)) u_addmod (
    .a (work_q),
    .b (add_b),
    .m (mod_q),
    .y (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && mod_ok) state_nxt = DOUBLE;
      DOUBLE:  if (cnt_tc) state_nxt = FILL;
      FILL:    if (cnt_tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state != IDLE);
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    if (state == IDLE && load_valid && mod_ok) begin
      mem_we = 1'b1;
    end else if (state == FILL && !cnt_tc) begin
      mem_we    = 1'b1;
      mem_waddr = wr_idx_q;
      mem_wdata = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept && mod_ok) tv_q <= 1'b0;
      if (accept && !mod_ok) err_q <= 1'b1;
      if (state == FILL && cnt_tc) begin
        tv_q   <= 1'b1;
        done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: if (accept && mod_ok) begin
        mod_q  <= modulus_in;
        work_q <= MODULUS_WIDTH'(1);
        cnt_q  <= CW'(LOW_POS);
      end
      DOUBLE: begin
        if (cnt_tc) begin
          step_q   <= sum;
          work_q   <= '0;
          cnt_q    <= CW'(DEPTH);
          wr_idx_q <= DIGIT_BITS'(1);
        end else begin
          work_q <= sum;
          cnt_q  <= cnt_q - CW'(1);
        end
      end
      FILL: begin
        work_q   <= sum;
        cnt_q    <= cnt_q - CW'(1);
        wr_idx_q <= wr_idx_q + DIGIT_BITS'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Gate on the registered valid flag so a partially built table never leaks out.
  always_ff @(posedge clk) begin
    if (reset)     rd_q <= '0;
    else if (tv_q) rd_q <= mem[rd_digit];
    else           rd_q <= '0;
  end

`ifdef MODLUT_OUT_REG_EN
  logic [MODULUS_WIDTH-1:0] rd_q2;

  always_ff @(posedge clk) begin
    if (reset) rd_q2 <= '0;
    else       rd_q2 <= rd_q;
  end

  assign rd_data = rd_q2;
`else
  assign rd_data = rd_q;
`endif

  assign done        = done_q;
  assign load_err    = err_q;
  assign table_valid = tv_q;

endmodule

// File: tb/tb_modulus_lut_gen.sv
// Randomized bench for modulus_lut_gen: three instances (two small, one default) against an arithmetic model.
`ifndef MODULUS_DEF
`define MODULUS_DEF {1'b1, 1022'd0, 1'b1}
`endif

module tb_modulus_lut_gen;

`ifdef MODLUT_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst, lv, rdy, bsy, dn, er, tv;
  logic [1023:0] mdrv;
  logic [5:0]    rdrv;
  logic [7:0]    rd_a, rd_b;
  logic [1023:0] rd_c;
  logic [1023:0] rdat [3];

  int n_chk  = 0;
  int n_fail = 0;

  modulus_lut_gen #(.MODULUS_WIDTH(8), .DIGIT_BITS(2), .LOW_POS(4)) dut_a (
    .clk(clk), .reset(rst[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
    .modulus_in(mdrv[7:0]), .busy(bsy[0]), .done(dn[0]), .load_err(er[0]),
    .table_valid(tv[0]), .rd_digit(rdrv[1:0]), .rd_data(rd_a));

  modulus_lut_gen #(.MODULUS_WIDTH(8), .DIGIT_BITS(3), .LOW_POS(3)) dut_b (
    .clk(clk), .reset(rst[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
    .modulus_in(mdrv[7:0]), .busy(bsy[1]), .done(dn[1]), .load_err(er[1]),
    .table_valid(tv[1]), .rd_digit(rdrv[2:0]), .rd_data(rd_b));

  modulus_lut_gen dut_c (
    .clk(clk), .reset(rst[2]), .load_valid(lv[2]), .load_ready(rdy[2]),
    .modulus_in(mdrv), .busy(bsy[2]), .done(dn[2]), .load_err(er[2]),
    .table_valid(tv[2]), .rd_digit(rdrv), .rd_data(rd_c));

  assign rdat[0] = {1016'b0, rd_a};
  assign rdat[1] = {1016'b0, rd_b};
  assign rdat[2] = rd_c;

  function automatic int lp_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 3 : 2042;
  endfunction

  function automatic int db_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 3 : 6;
  endfunction

  // entry[i] = (i * 2^lp) mod m, straight from the definition.
  function automatic logic [1023:0] model_entry(input int i, input int lp, input logic [1023:0] m);
    logic [2111:0] x;
    x = 2112'(i) << lp;
    x = x % {1088'b0, m};
    return x[1023:0];
  endfunction

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = $urandom;
    v[1023] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic read_table(input int s, input logic [1023:0] m);
    for (int i = 0; i < (1 << db_of(s)); i++) begin
      rdrv = 6'(i);
      repeat (RD_LAT) step();
      chk($sformatf("entry_d%0d_i%0d", s, i), rdat[s], model_entry(i, lp_of(s), m));
    end
  endtask

  // Called right after the accepting edge; optionally offers a stray load during FILL.
  task automatic wait_done(input int s, input int inject_at);
    int cyc;
    int nb;
    int lat;
    cyc = 0;
    nb  = 0;
    lat = lp_of(s) + (1 << db_of(s));
    while (!dn[s] && cyc < lat + 10) begin
      if (bsy[s]) nb++;
      if (inject_at >= 0 && cyc == inject_at) begin
        lv[s] = 1'b1;
        mdrv  = 1024'd5;
      end
      if (inject_at >= 0 && cyc >= inject_at && cyc < inject_at + 2)
        chk("ready_in_fill", rdy[s], 1'b0);
      if (inject_at >= 0 && cyc == inject_at + 2) lv[s] = 1'b0;
      step();
      cyc++;
    end
    if (inject_at >= 0) lv[s] = 1'b0;
    chk("gen_latency", cyc, lat);
    chk("busy_cycles", nb, lat);
    chk("tv_at_done", tv[s], 1'b1);
    chk("busy_at_done", bsy[s], 1'b0);
    chk("ready_at_done", rdy[s], 1'b1);
    chk("rd_at_done", rdat[s], '0);
    step();
    chk("done_pulse", dn[s], 1'b0);
  endtask

  task automatic do_load(input int s, input logic [1023:0] m, input int inject_at);
    logic tv_before;
    tv_before = tv[s];
    lv[s] = 1'b1;
    mdrv  = m;
    chk("ready_idle", rdy[s], 1'b1);
    step();
    lv[s] = 1'b0;
    if (m < 2) begin
      chk("err_pulse", er[s], 1'b1);
      chk("err_busy", bsy[s], 1'b0);
      chk("err_tv_kept", tv[s], tv_before);
      step();
      chk("err_clear", er[s], 1'b0);
      chk("err_idle", bsy[s], 1'b0);
    end else begin
      chk("busy_start", bsy[s], 1'b1);
      chk("tv_drop", tv[s], 1'b0);
      chk("done_early", dn[s], 1'b0);
      wait_done(s, inject_at);
    end
  endtask

  initial begin
    logic [1023:0] m;
    int seen;
    rst  = '1;
    lv   = '0;
    mdrv = '0;
    rdrv = '0;
    repeat (3) step();
    rst = '0;

    for (int s = 0; s < 3; s++) begin
      chk("rst_ready", rdy[s], 1'b1);
      chk("rst_busy", bsy[s], 1'b0);
      chk("rst_done", dn[s], 1'b0);
      chk("rst_err", er[s], 1'b0);
      chk("rst_tv", tv[s], 1'b0);
      chk("rst_rd", rdat[s], '0);
    end

    rdrv = 6'd1;
    do_load(0, 1024'd13, -1);
    read_table(0, 1024'd13);

    rdrv = 6'd1;
    do_load(0, 1024'd1, -1);
    do_load(0, 1024'd0, -1);
    read_table(0, 1024'd13);

    rdrv = 6'd1;
    do_load(1, 1024'd7, -1);
    read_table(1, 1024'd7);

    // held load_valid: second modulus taken on the edge after done
    rdrv  = 6'd2;
    lv[0] = 1'b1;
    mdrv  = 1024'd13;
    chk("b2b_ready", rdy[0], 1'b1);
    step();
    mdrv = 1024'd11;
    chk("b2b_busy1", bsy[0], 1'b1);
    wait_done(0, -1);
    lv[0] = 1'b0;
    chk("b2b_busy2", bsy[0], 1'b1);
    chk("b2b_tv_drop", tv[0], 1'b0);
    wait_done(0, -1);
    read_table(0, 1024'd11);

    rdrv = 6'd1;
    do_load(0, 1024'd13, lp_of(0) + 1);
    read_table(0, 1024'd13);

    // reset in the middle of doubling
    lv[0] = 1'b1;
    mdrv  = 1024'd11;
    step();
    lv[0] = 1'b0;
    step();
    chk("mid_busy", bsy[0], 1'b1);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("mrst_ready", rdy[0], 1'b1);
    chk("mrst_busy", bsy[0], 1'b0);
    chk("mrst_tv", tv[0], 1'b0);
    chk("mrst_rd", rdat[0], '0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dn[0] || bsy[0]) seen++;
    end
    chk("abandoned", seen, 0);
    rdrv = 6'd1;
    repeat (RD_LAT) step();
    chk("rd_gated", rdat[0], '0);
    do_load(0, 1024'd11, -1);
    read_table(0, 1024'd11);

    for (int k = 0; k < 4; k++) begin
      m = 1024'($urandom_range(2, 255));
      do_load(0, m, -1);
      read_table(0, m);
      m = 1024'($urandom_range(2, 255));
      do_load(1, m, -1);
      read_table(1, m);
    end

    m = `MODULUS_DEF;
    do_load(2, m, -1);
    read_table(2, m);
    m = rand_wide();
    do_load(2, m, -1);
    read_table(2, m);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
